// File: rtl/reg_alu_seq_if.sv
// Issue/result bus between the instruction-issue controller and reg_alu_seq.
// master: issuing controller; slave: reg_alu_seq.
interface reg_alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
);
  localparam int AW = $clog2(NREG);

  logic             in_valid;
  logic             in_ready;
  logic             ext_wr;
  logic [2:0]       op;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] d_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;

  modport master (
    output in_valid, ext_wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
    input  in_ready, out_valid, result, cout, zero
  );

  modport slave (
    input  in_valid, ext_wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
    output in_ready, out_valid, result, cout, zero
  );
endinterface

// File: rtl/reg_alu_seq.sv
// Sequenced register-file ALU: one operation per handshake, operands read in
// READ, computed in EXEC, written back (with flag update) in WB.
// Optional macro REG_ALU_SEQ_ZERO_REG_EN: register 0 reads as 0 and ignores writes.
//
// state | meaning
// IDLE  | ready for a new operation (in_ready=1)
// READ  | latch reg[a], reg[b] into operand registers
// EXEC  | compute result and pending flags
// WB    | write reg[wr_addr], pulse out_valid, commit flags (ALU ops only)
module reg_alu_seq #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic          clk,
  input  logic          reset,
  reg_alu_seq_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic             ext_q, ext_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_nx_q, cout_nx_d, zero_nx_q, zero_nx_d;
  logic             cout_q, cout_d, zero_q, zero_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_en;

  assign accept = bus.in_valid && (state_q == IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = bus.ext_wr ? WB : READ;
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and registered datapath outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == WB);
    bus.result    = result_q;
    bus.cout      = cout_q;
    bus.zero      = zero_q;
  end

  // Register-file read ports; register 0 may be hardwired to zero
  always_comb begin
    rd_a = regs_q[ra_q];
    rd_b = regs_q[rb_q];
`ifdef REG_ALU_SEQ_ZERO_REG_EN
    if (ra_q == '0) rd_a = '0;
    if (rb_q == '0) rd_b = '0;
`endif
  end

  // ALU: carry computed over WIDTH+1 bits; logic ops hold the carry flag
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = cout_q;
    case (op_q)
      3'b000: begin
        sum = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH];
      end
      3'b001: begin
        sum = {1'b0, opa_q} + {1'b0, ~opb_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH];
      end
      3'b010: alu_res = opa_q & opb_q;
      3'b011: alu_res = opa_q | opb_q;
      3'b100: alu_res = opa_q ^ opb_q;
      3'b101: begin
        sum = {1'b0, opa_q} + {1'b0, opb_q} + {{WIDTH{1'b0}}, cout_q};
        alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH];
      end
      3'b110: begin alu_res = {opa_q[WIDTH-2:0], 1'b0}; alu_c = opa_q[WIDTH-1]; end
      3'b111: begin alu_res = {1'b0, opa_q[WIDTH-1:1]}; alu_c = opa_q[0]; end
      default: ;
    endcase
  end

  // Datapath next-state: capture on accept, read, execute, write back
  always_comb begin
    op_d      = op_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    wa_d      = wa_q;
    ext_d     = ext_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    cout_nx_d = cout_nx_q;
    zero_nx_d = zero_nx_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    regs_d    = regs_q;
    wr_en     = 1'b1;
`ifdef REG_ALU_SEQ_ZERO_REG_EN
    if (wa_q == '0) wr_en = 1'b0;
`endif
    case (state_q)
      IDLE: if (accept) begin
        op_d  = bus.op;
        ra_d  = bus.rd_addr_a;
        rb_d  = bus.rd_addr_b;
        wa_d  = bus.wr_addr;
        ext_d = bus.ext_wr;
        if (bus.ext_wr) result_d = bus.d_in;
      end
      READ: begin
        opa_d = rd_a;
        opb_d = rd_b;
      end
      EXEC: begin
        result_d  = alu_res;
        cout_nx_d = alu_c;
        zero_nx_d = (alu_res == '0);
      end
      WB: begin
        if (wr_en) regs_d[wa_q] = result_q;
        if (!ext_q) begin
          cout_d = cout_nx_q;
          zero_d = zero_nx_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, including the register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      wa_q      <= '0;
      ext_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cout_nx_q <= 1'b0;
      zero_nx_q <= 1'b0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      wa_q      <= wa_d;
      ext_q     <= ext_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      cout_nx_q <= cout_nx_d;
      zero_nx_q <= zero_nx_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_reg_alu_seq.sv
module tb_reg_alu_seq;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  reg_alu_seq_if #(.WIDTH(16), .NREG(8)) bus ();

  reg_alu_seq #(.WIDTH(16), .NREG(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ew, input logic [2:0] o, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] w, input logic [15:0] d);
    bus.in_valid  = 1'b1;
    bus.ext_wr    = ew;
    bus.op        = o;
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    bus.wr_addr   = w;
    bus.d_in      = d;
  endtask

  // One complete transaction: issue, measure latency, check result and flags.
  task automatic run_op(input string tag, input logic ew, input logic [2:0] o,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] w,
                        input logic [15:0] d, input int exp_lat, input logic [15:0] exp_res,
                        input logic exp_c, input logic exp_z);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, bus.in_ready, 1);
    drive(ew, o, a, b, w, d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, bus.result, exp_res);
    @(negedge clk);
    check({tag, "_ovlo"}, bus.out_valid, 0);
    check({tag, "_flags"}, {bus.in_ready, bus.cout, bus.zero}, {1'b1, exp_c, exp_z});
  endtask

  initial begin
    logic seen_ov;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.ext_wr = 1'b0; bus.op = 3'd0;
    bus.rd_addr_a = 3'd0; bus.rd_addr_b = 3'd0; bus.wr_addr = 3'd0; bus.d_in = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_state", {bus.in_ready, bus.out_valid, bus.cout, bus.zero}, 4'b1000);
    check("rst_result", bus.result, 16'h0000);
    reset = 1'b1;

    run_op("ld_r1",   1, 3'b000, 0, 0, 1, 16'h1234, 1, 16'h1234, 0, 0);
    run_op("ld_r2",   1, 3'b000, 0, 0, 2, 16'h00FF, 1, 16'h00FF, 0, 0);
    run_op("add_r3",  0, 3'b000, 1, 2, 3, 16'hDEAD, 3, 16'h1333, 0, 0);
    run_op("sub_r4",  0, 3'b001, 2, 2, 4, 16'h0,    3, 16'h0000, 1, 1);
    run_op("ld_r5",   1, 3'b000, 0, 0, 5, 16'hFFFF, 1, 16'hFFFF, 1, 1);
    run_op("ld_r6",   1, 3'b000, 0, 0, 6, 16'h0001, 1, 16'h0001, 1, 1);
    run_op("add_r7",  0, 3'b000, 5, 6, 7, 16'h0,    3, 16'h0000, 1, 1);
    run_op("adc_r7",  0, 3'b101, 6, 6, 7, 16'h0,    3, 16'h0003, 0, 0);
    run_op("shl",     0, 3'b110, 5, 0, 4, 16'h0,    3, 16'hFFFE, 1, 0);
    run_op("shr",     0, 3'b111, 6, 0, 4, 16'h0,    3, 16'h0000, 1, 1);
    run_op("xor",     0, 3'b100, 1, 2, 4, 16'h0,    3, 16'h12CB, 1, 0);
    run_op("sub_bor", 0, 3'b001, 2, 1, 4, 16'h0,    3, 16'hEECB, 0, 0);
    run_op("and",     0, 3'b010, 1, 2, 4, 16'h0,    3, 16'h0034, 0, 0);
    run_op("or",      0, 3'b011, 1, 2, 4, 16'h0,    3, 16'h12FF, 0, 0);
    run_op("add_self",0, 3'b000, 1, 1, 1, 16'h0,    3, 16'h2468, 0, 0);

    // in_valid held high across two operations; fields switch right after accept
    @(negedge clk);
    drive(0, 3'b000, 1, 2, 3, 16'h0);
    @(negedge clk);
    drive(1, 3'b000, 0, 0, 6, 16'h5555);
    check("b2b_c1", {bus.in_ready, bus.out_valid}, 2'b00);
    @(negedge clk);
    check("b2b_c2", {bus.in_ready, bus.out_valid}, 2'b00);
    @(negedge clk);
    check("b2b_c3", {bus.in_ready, bus.out_valid}, 2'b01);
    check("b2b_res1", bus.result, 16'h2567);
    @(negedge clk);
    check("b2b_c4", {bus.in_ready, bus.out_valid}, 2'b10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b_c5", {bus.in_ready, bus.out_valid}, 2'b01);
    check("b2b_res2", bus.result, 16'h5555);
    @(negedge clk);
    check("b2b_flags", {bus.in_ready, bus.cout, bus.zero}, 3'b100);
    run_op("rd_r3",   0, 3'b011, 3, 3, 7, 16'h0,    3, 16'h2567, 0, 0);
    run_op("rd_r6",   0, 3'b011, 6, 6, 7, 16'h0,    3, 16'h5555, 0, 0);

    // Reset pulsed while an ADD into r3 sits in EXEC
    @(negedge clk);
    drive(0, 3'b000, 1, 2, 3, 16'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid", {bus.in_ready, bus.out_valid}, 2'b10);
    check("rst_mid_res", bus.result, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen_ov = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen_ov = 1'b1;
    end
    check("rst_no_wb", {seen_ov, bus.in_ready}, 2'b01);
    run_op("rd_r3_rst", 0, 3'b011, 3, 3, 7, 16'h0,  3, 16'h0000, 0, 1);
    run_op("rd_r1_rst", 0, 3'b000, 1, 2, 7, 16'h0,  3, 16'h0000, 0, 1);

    run_op("ld_r0",   1, 3'b000, 0, 0, 0, 16'hABCD, 1, 16'hABCD, 0, 1);
`ifdef REG_ALU_SEQ_ZERO_REG_EN
    run_op("add_r0",  0, 3'b000, 0, 0, 1, 16'h0,    3, 16'h0000, 0, 1);
`else
    run_op("add_r0",  0, 3'b000, 0, 0, 1, 16'h0,    3, 16'h579A, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
